instr_mem_banked: RTL and testbench

Parametrised, loadable successor to the fixed instruction ROMs. Holds NUM_BANKS independent programs of up to DEPTH instruction words each. Programs are loaded through a streaming handshake port. Fetch is synchronous, with one-cycle latency, stall/flush control and field decode. Sits between the PC/fetch stage and the decoder of the 9-bit accumulator-style core.

---
 rtl/instr_mem_banked_pkg.sv | 18 +
 rtl/instr_bank_ram.sv | 23 ++
 rtl/instr_mem_banked.sv | 157 +++++++++++++++
 tb/tb_instr_mem_banked.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_banked_pkg.sv
// Shared constants for the banked, loadable instruction memory.
package instr_mem_banked_pkg;

    localparam int INSTR_W_DEF = 9;
    localparam logic [INSTR_W_DEF-1:0] NOP_WORD_DEF = '0;

    // Decode fields are placed relative to the MSB so wider words keep the layout.
    localparam int OPC_OFS = 1;   // opcode MSB sits one below the format bit
    localparam int OPC_W   = 4;
    localparam int SGN_OFS = 5;   // sign bit sits five below the format bit
    localparam int OPR_W   = 3;   // operand is always the low bits

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

endpackage

// File: rtl/instr_bank_ram.sv
// Single-port storage for all banks, addressed {bank, word}; sync write, sync read.
module instr_bank_ram #(
    parameter int W     = 9,
    parameter int WORDS = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [WORDS];

    // Read data only updates on a read, so it doubles as the held fetch word.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/instr_mem_banked.sv
// Banked instruction memory: streaming program loader plus 1-cycle fetch with stall/flush.
module instr_mem_banked
    import instr_mem_banked_pkg::*;
#(
    parameter int INSTR_W   = INSTR_W_DEF,
    parameter int DEPTH     = 128,
    parameter int NUM_BANKS = 2,
    parameter int PC_W      = 16,
    parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(NOP_WORD_DEF),
    localparam int SEL_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SEL_W-1:0]   prog_sel,
    input  logic               load_start,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    output logic               load_done,
    input  logic               fetch_en,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               stall,
    input  logic               flush,
    output logic               instr_valid,
    output logic               format,
    output logic [OPC_W-1:0]   opcode,
    output logic               sign,
    output logic [OPR_W-1:0]   operand,
    output logic [INSTR_W-2:0] immediate,
    output logic               oob
);

    localparam int AW     = $clog2(DEPTH);
    localparam int LEN_W  = AW + 1;                 // lengths run 0..DEPTH
    localparam int CMP_W  = (PC_W > LEN_W) ? PC_W : LEN_W;
    localparam int RAM_AW = SEL_W + AW;

    state_t             state, state_nxt;
    logic [SEL_W-1:0]   load_bank;
    logic [LEN_W-1:0]   wr_cnt;
    logic [LEN_W-1:0]   bank_len [NUM_BANKS];
    logic               load_done_q;
    logic               instr_valid_q;
    logic               oob_q;
    logic               nop_sel_q;        // output shows NOP_WORD instead of RAM data
    logic               ready_c;
    logic               wr_acc;
    logic               load_fin;
    logic               sel_ok;
    logic [LEN_W-1:0]   cur_len;
    logic               in_range;
    logic               ram_re;
    logic [RAM_AW-1:0]  ram_addr;
    logic [INSTR_W-1:0] ram_rdata;
    logic [INSTR_W-1:0] instr_q;

    // Selects beyond NUM_BANKS (non power-of-two bank counts) behave as empty banks.
    assign sel_ok   = (32'(prog_sel) < NUM_BANKS);
    assign cur_len  = sel_ok ? bank_len[prog_sel] : '0;
    assign in_range = (CMP_W'(pc_in) < CMP_W'(cur_len));

    // Loader FSM next state, handshake and end-of-program detection.
    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        wr_acc    = 1'b0;
        load_fin  = 1'b0;
        case (state)
            ST_IDLE: if (load_start && sel_ok) state_nxt = ST_LOAD;
            ST_LOAD: begin
                ready_c = (wr_cnt < LEN_W'(DEPTH));
                wr_acc  = load_valid && ready_c;
                if (wr_acc && (load_last || wr_cnt == LEN_W'(DEPTH - 1))) begin
                    load_fin  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Loader state, write counter and per-bank committed lengths.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            load_bank   <= '0;
            wr_cnt      <= '0;
            load_done_q <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) bank_len[b] <= '0;
        end else begin
            state       <= state_nxt;
            load_done_q <= load_fin;
            if (state == ST_IDLE && state_nxt == ST_LOAD) begin
                // Bank reads as unloaded from the moment a reload begins.
                load_bank          <= prog_sel;
                wr_cnt             <= '0;
                bank_len[prog_sel] <= '0;
            end else if (wr_acc) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (load_fin) bank_len[load_bank] <= wr_cnt + 1'b1;
            end
        end
    end

    // Loads and fetches never overlap (fetch only in IDLE), so one port suffices.
    assign ram_re   = (state == ST_IDLE) && fetch_en && !stall && !flush && in_range;
    assign ram_addr = (state == ST_LOAD) ? {load_bank, wr_cnt[AW-1:0]}
                                         : {prog_sel, pc_in[AW-1:0]};

    instr_bank_ram #(
        .W     (INSTR_W),
        .WORDS (NUM_BANKS * DEPTH),
        .AW    (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (load_data),
        .rdata (ram_rdata)
    );

    // Fetch status: flush beats stall beats fetch; LOAD just drops valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_valid_q <= 1'b0;
            oob_q         <= 1'b0;
            nop_sel_q     <= 1'b1;
        end else if (flush) begin
            instr_valid_q <= 1'b0;
            oob_q         <= 1'b0;
            nop_sel_q     <= 1'b1;
        end else if (!stall) begin
            if (state == ST_IDLE && fetch_en) begin
                instr_valid_q <= 1'b1;
                oob_q         <= !in_range;
                nop_sel_q     <= !in_range;
            end else begin
                instr_valid_q <= 1'b0;
            end
        end
    end

    assign instr_q     = nop_sel_q ? NOP_WORD : ram_rdata;
    assign instr_valid = instr_valid_q;
    assign oob         = oob_q;
    assign load_ready  = ready_c;
    assign load_done   = load_done_q;

    assign format    = instr_q[INSTR_W-1];
    assign opcode    = instr_q[INSTR_W-1-OPC_OFS -: OPC_W];
    assign sign      = instr_q[INSTR_W-1-SGN_OFS];
    assign operand   = instr_q[OPR_W-1:0];
    assign immediate = instr_q[INSTR_W-2:0];

endmodule

// File: tb/tb_instr_mem_banked.sv
// Directed bench for instr_mem_banked: load, fetch, stall/flush, full-depth and reset-abort.
module tb_instr_mem_banked;

    localparam int DEPTH = 128;

    logic       clk = 1'b0;
    logic       reset, load_start, load_valid, load_last, fetch_en, stall, flush;
    logic [0:0] prog_sel;
    logic [8:0] load_data;
    logic [15:0] pc_in;
    logic       load_ready, load_done, instr_valid, format, sign, oob;
    logic [3:0] opcode;
    logic [2:0] operand;
    logic [7:0] immediate;
    logic [8:0] instr_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign instr_o = {format, immediate};

    instr_mem_banked #(
        .INSTR_W   (9),
        .DEPTH     (DEPTH),
        .NUM_BANKS (2),
        .PC_W      (16),
        .NOP_WORD  (9'b000000000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .prog_sel    (prog_sel),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .fetch_en    (fetch_en),
        .pc_in       (pc_in),
        .stall       (stall),
        .flush       (flush),
        .instr_valid (instr_valid),
        .format      (format),
        .opcode      (opcode),
        .sign        (sign),
        .operand     (operand),
        .immediate   (immediate),
        .oob         (oob)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one fetch for a single edge; outputs are checked at the following negedge.
    task automatic do_fetch(input logic [0:0] sel, input logic [15:0] pc);
        prog_sel = sel;
        pc_in    = pc;
        fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0;
    endtask

    initial begin
        logic [8:0] w0 [3];
        w0[0] = 9'b101111000;
        w0[1] = 9'b010000000;
        w0[2] = 9'b110110000;

        reset = 1'b1; load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
        fetch_en = 0; stall = 0; flush = 0; prog_sel = '0; pc_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // reset state
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_oob",   32'(oob),         32'd0);
        chk("rst_ready", 32'(load_ready),  32'd0);
        chk("rst_done",  32'(load_done),   32'd0);
        chk("rst_instr", 32'(instr_o),     32'd0);

        // fetch from an unloaded bank
        do_fetch(1'b0, 16'd0);
        chk("empty_valid", 32'(instr_valid), 32'd1);
        chk("empty_oob",   32'(oob),         32'd1);
        chk("empty_instr", 32'(instr_o),     32'd0);
        chk("empty_opc",   32'(opcode),      32'd0);

        // load bank0 with three words
        prog_sel = 1'b0; load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = w0[i]; load_last = (i == 2);
            chk("ld0_ready", 32'(load_ready), 32'd1);
            @(negedge clk);
        end
        load_valid = 1'b0; load_last = 1'b0;
        chk("ld0_done",      32'(load_done),  32'd1);
        chk("ld0_ready_end", 32'(load_ready), 32'd0);
        @(negedge clk);
        chk("ld0_done_once", 32'(load_done),  32'd0);

        do_fetch(1'b0, 16'd1);
        chk("pc1_valid",   32'(instr_valid), 32'd1);
        chk("pc1_format",  32'(format),      32'd0);
        chk("pc1_opcode",  32'(opcode),      32'b1000);
        chk("pc1_sign",    32'(sign),        32'd0);
        chk("pc1_operand", 32'(operand),     32'd0);
        chk("pc1_imm",     32'(immediate),   32'b10000000);
        chk("pc1_oob",     32'(oob),         32'd0);

        do_fetch(1'b0, 16'd3);
        chk("pc3_oob",   32'(oob),     32'd1);
        chk("pc3_instr", 32'(instr_o), 32'd0);

        // load bank1 with a single word
        prog_sel = 1'b1; load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0; load_valid = 1'b1; load_data = 9'b100010110; load_last = 1'b1;
        @(negedge clk);
        load_valid = 1'b0; load_last = 1'b0;
        chk("ld1_done", 32'(load_done), 32'd1);

        // alternate banks at pc 0 on consecutive cycles
        fetch_en = 1'b1; pc_in = 16'd0; prog_sel = 1'b0;
        @(negedge clk);
        chk("alt_b0", 32'(instr_o), 32'b101111000);
        prog_sel = 1'b1;
        @(negedge clk);
        chk("alt_b1", 32'(instr_o), 32'b100010110);
        chk("alt_b1_sign", 32'(sign), 32'd0);
        chk("alt_b1_opr",  32'(operand), 32'b110);
        fetch_en = 1'b0;

        // stall holds while pc moves, then flush kills
        do_fetch(1'b0, 16'd2);
        chk("pc2_instr", 32'(instr_o), 32'b110110000);
        stall = 1'b1; fetch_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_in = 16'(i);
            @(negedge clk);
            chk("stall_instr", 32'(instr_o),     32'b110110000);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_oob",   32'(oob),         32'd0);
        end
        stall = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; fetch_en = 1'b0;
        chk("flush_valid", 32'(instr_valid), 32'd0);
        chk("flush_instr", 32'(instr_o),     32'd0);
        chk("flush_oob",   32'(oob),         32'd0);

        // stream DEPTH+2 words into bank1 without load_last
        prog_sel = 1'b1; load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            load_valid = 1'b1; load_data = 9'(i + 3);
            chk("full_ready", 32'(load_ready), (i < DEPTH) ? 32'd1 : 32'd0);
            if (i == DEPTH) chk("full_done", 32'(load_done), 32'd1);
            @(negedge clk);
        end
        load_valid = 1'b0;
        do_fetch(1'b1, 16'(DEPTH - 1));
        chk("full_last_valid", 32'(instr_valid), 32'd1);
        chk("full_last_oob",   32'(oob),         32'd0);
        chk("full_last_instr", 32'(instr_o),     32'(DEPTH + 2));
        do_fetch(1'b1, 16'(DEPTH));
        chk("full_over_oob",   32'(oob),         32'd1);
        chk("full_over_instr", 32'(instr_o),     32'd0);
        do_fetch(1'b1, 16'd0);
        chk("full_first", 32'(instr_o), 32'd3);
        do_fetch(1'b0, 16'd2);
        chk("b0_intact", 32'(instr_o), 32'b110110000);

        // reset part way through a load; fetches inside LOAD are ignored
        prog_sel = 1'b0; load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0; fetch_en = 1'b1; pc_in = 16'd0;
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1; load_data = 9'(i);
            @(negedge clk);
        end
        chk("load_fetch_valid", 32'(instr_valid), 32'd0);
        chk("load_fetch_hold",  32'(instr_o),     32'b110110000);
        fetch_en = 1'b0; load_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", 32'(load_ready),  32'd0);
        chk("abort_valid", 32'(instr_valid), 32'd0);
        do_fetch(1'b0, 16'd0);
        chk("abort_b0_oob", 32'(oob), 32'd1);
        do_fetch(1'b1, 16'd0);
        chk("abort_b1_oob", 32'(oob), 32'd1);
        chk("abort_b1_instr", 32'(instr_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
